ham_decode_arbiter: RTL and testbench

Shares one combinational ham_decoder (Hamming(7,4), 7-bit message in, 7-bit corrected word out) among NREQ requesters. The block has three parts:
- A round-robin arbiter that grants at most one requester per cycle.
- A one-deep registered output stage with valid/ready backpressure.
- A saturating counter of single-bit corrections.
It sits between the codeword sources and the downstream data consumer.

---
 rtl/ham_decode_arbiter.sv | 129 ++++++++++++
 tb/tb_ham_decode_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ham_decode_arbiter.sv
// Round-robin arbiter sharing one Hamming(7,4) corrector among NREQ sources,
// feeding a one-deep valid/ready output register and a saturating correction counter.
module ham_decode_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int CNT_W = 16,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [7*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [6:0]        out_data,
  output logic [3:0]        out_nibble,
  output logic [IDW-1:0]    out_id,
  output logic              out_corrected,
  output logic [CNT_W-1:0]  corr_count,
  input  logic              cnt_clear
);

  // Single-error correction: nonzero syndrome s names Hamming position s, i.e. bit s-1.
  function automatic logic [6:0] ham_fix(input logic [6:0] m);
    logic [2:0] syn;
    logic [6:0] fixed;
    syn   = {m[3] ^ m[4] ^ m[5] ^ m[6],
             m[1] ^ m[2] ^ m[5] ^ m[6],
             m[0] ^ m[2] ^ m[4] ^ m[6]};
    fixed = m;
    if (syn != 3'd0) fixed[syn - 3'd1] = ~m[syn - 3'd1];
    return fixed;
  endfunction

  logic             out_valid_q, out_valid_d;
  logic [6:0]       out_data_q, out_data_d;
  logic [3:0]       out_nibble_q, out_nibble_d;
  logic [IDW-1:0]   out_id_q, out_id_d;
  logic             out_corrected_q, out_corrected_d;
  logic [CNT_W-1:0] corr_count_q, corr_count_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;

  logic             advance;
  logic             grant_any;
  logic [IDW-1:0]   grant_idx;
  logic [6:0]       raw_word;
  logic [6:0]       fixed_word;
  logic             xfer;
  logic             was_fixed;

  always_comb begin
    int cand;
    advance   = ~out_valid_q | out_ready;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!grant_any && req_valid[IDW'(cand)]) begin
        grant_any = 1'b1;
        grant_idx = IDW'(cand);
      end
    end

    req_ready = '0;
    raw_word  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx == IDW'(k)) begin
        raw_word = req_data[7*k +: 7];
        // Gated by reset so nothing is handshaken in the reset cycle.
        req_ready[k] = advance & grant_any & ~reset;
      end
    end

    fixed_word = ham_fix(raw_word);
    was_fixed  = (fixed_word != raw_word);
    xfer       = |(req_valid & req_ready);

    out_valid_d     = out_valid_q;
    out_data_d      = out_data_q;
    out_nibble_d    = out_nibble_q;
    out_id_d        = out_id_q;
    out_corrected_d = out_corrected_q;
    rr_ptr_d        = rr_ptr_q;
    if (advance) out_valid_d = xfer;
    if (xfer) begin
      out_data_d      = fixed_word;
      out_nibble_d    = {fixed_word[6], fixed_word[5], fixed_word[4], fixed_word[2]};
      out_id_d        = grant_idx;
      out_corrected_d = was_fixed;
      rr_ptr_d        = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    corr_count_d = corr_count_q;
    if (cnt_clear)
      corr_count_d = '0;
    else if (xfer && was_fixed && (corr_count_q != {CNT_W{1'b1}}))
      corr_count_d = corr_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_nibble_q    <= '0;
      out_id_q        <= '0;
      out_corrected_q <= 1'b0;
      corr_count_q    <= '0;
      rr_ptr_q        <= '0;
    end else begin
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_nibble_q    <= out_nibble_d;
      out_id_q        <= out_id_d;
      out_corrected_q <= out_corrected_d;
      corr_count_q    <= corr_count_d;
      rr_ptr_q        <= rr_ptr_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_nibble    = out_nibble_q;
  assign out_id        = out_id_q;
  assign out_corrected = out_corrected_q;
  assign corr_count    = corr_count_q;

endmodule

// File: tb/tb_ham_decode_arbiter.sv
// Directed bench for ham_decode_arbiter; a second instance with a 2-bit counter
// shares the stimulus to exercise saturation.
module tb_ham_decode_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NREQ-1:0]  req_valid;
  logic [7*NREQ-1:0] req_data;
  logic             out_ready;
  logic             cnt_clear;

  logic [NREQ-1:0]  req_ready, req_ready2;
  logic             out_valid, out_valid2;
  logic [6:0]       out_data, out_data2;
  logic [3:0]       out_nibble, out_nibble2;
  logic [IDW-1:0]   out_id, out_id2;
  logic             out_corrected, out_corrected2;
  logic [15:0]      corr_count;
  logic [1:0]       corr_count2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ham_decode_arbiter #(.NREQ(NREQ), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_nibble(out_nibble), .out_id(out_id),
    .out_corrected(out_corrected), .corr_count(corr_count), .cnt_clear(cnt_clear)
  );

  ham_decode_arbiter #(.NREQ(NREQ), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready2), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_nibble(out_nibble2), .out_id(out_id2),
    .out_corrected(out_corrected2), .corr_count(corr_count2), .cnt_clear(cnt_clear)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [6:0] d);
    req_valid[i]       = 1'b1;
    req_data[7*i +: 7] = d;
  endtask

  task automatic clr_req();
    req_valid = '0;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b1;
    cnt_clear = 1'b0;
    tick();
    tick();

    // reset state, and no handshake while reset is high
    req_valid = 4'hF;
    #1;
    check("rst_req_ready", req_ready, 4'b0000);
    clr_req();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_nibble", out_nibble, 0);
    check("rst_out_id", out_id, 0);
    check("rst_out_corr", out_corrected, 0);
    check("rst_count", corr_count, 0);
    reset = 1'b0;

    // clean codeword from requester 0
    set_req(0, 7'h66);
    #1;
    check("t1_req_ready", req_ready, 4'b0001);
    tick();
    clr_req();
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 7'h66);
    check("t1_nibble", out_nibble, 4'hD);
    check("t1_id", out_id, 0);
    check("t1_corr", out_corrected, 0);
    check("t1_count", corr_count, 0);

    // single-bit error on m4 from requester 2
    set_req(2, 7'h76);
    #1;
    check("t2_req_ready", req_ready, 4'b0100);
    tick();
    clr_req();
    check("t2_data", out_data, 7'h66);
    check("t2_id", out_id, 2);
    check("t2_corr", out_corrected, 1);
    check("t2_count", corr_count, 1);

    set_req(2, 7'h00);
    tick();
    clr_req();
    check("t2_zero_data", out_data, 7'h00);
    check("t2_zero_corr", out_corrected, 0);
    set_req(2, 7'h7F);
    tick();
    clr_req();
    check("t2_ones_data", out_data, 7'h7F);
    check("t2_ones_nibble", out_nibble, 4'hF);
    check("t2_ones_corr", out_corrected, 0);
    check("t2_count_hold", corr_count, 1);

    // requester 3 alone brings the pointer back to 0
    set_req(3, 7'h19);
    tick();
    check("t3_pre_id", out_id, 3);
    check("t3_pre_data", out_data, 7'h19);

    set_req(0, 7'h00);
    set_req(1, 7'h7F);
    set_req(2, 7'h66);
    set_req(3, 7'h19);
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("t3_rr_valid_%0d", k), out_valid, 1);
      check($sformatf("t3_rr_id_%0d", k), out_id, k % 4);
    end
    req_valid[1] = 1'b0;
    begin
      logic [IDW-1:0] seq [4];
      seq = '{2'd0, 2'd2, 2'd3, 2'd0};
      for (int k = 0; k < 4; k++) begin
        tick();
        check($sformatf("t3_skip_id_%0d", k), out_id, seq[k]);
      end
    end
    clr_req();
    tick();
    check("t3_idle_valid", out_valid, 0);
    check("t3_count", corr_count, 1);

    // backpressure; pointer is at 1
    set_req(0, 7'h76);
    tick();
    clr_req();
    check("t4_first_id", out_id, 0);
    check("t4_first_count", corr_count, 2);
    out_ready = 1'b0;
    set_req(0, 7'h00);
    set_req(1, 7'h76);
    set_req(2, 7'h7F);
    set_req(3, 7'h19);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("t4_stall_ready_%0d", k), req_ready, 4'b0000);
      tick();
      check($sformatf("t4_stall_valid_%0d", k), out_valid, 1);
      check($sformatf("t4_stall_id_%0d", k), out_id, 0);
      check($sformatf("t4_stall_data_%0d", k), out_data, 7'h66);
      check($sformatf("t4_stall_count_%0d", k), corr_count, 2);
    end
    out_ready = 1'b1;
    #1;
    check("t4_resume_ready", req_ready, 4'b0010);
    tick();
    clr_req();
    check("t4_resume_id", out_id, 1);
    check("t4_resume_data", out_data, 7'h66);
    check("t4_resume_count", corr_count, 3);
    tick();
    check("t4_idle_valid", out_valid, 0);

    // saturation on the 2-bit counter, then clear beats increment
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    check("t5_clear_count", corr_count, 0);
    check("t5_clear_count2", corr_count2, 0);
    set_req(0, 7'h76);
    for (int k = 0; k < 5; k++) tick();
    clr_req();
    check("t5_count", corr_count, 5);
    check("t5_sat_count2", corr_count2, 2'd3);
    set_req(0, 7'h76);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    clr_req();
    check("t5_clr_win_corr", out_corrected, 1);
    check("t5_clr_win_count", corr_count, 0);
    check("t5_clr_win_count2", corr_count2, 0);

    // reset while holding a word with the pointer at 3
    set_req(2, 7'h76);
    tick();
    check("t6_pre_valid", out_valid, 1);
    check("t6_pre_count", corr_count, 1);
    reset = 1'b1;
    req_valid = 4'hF;
    #1;
    check("t6_rst_ready", req_ready, 4'b0000);
    tick();
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_count", corr_count, 0);
    reset = 1'b0;
    #1;
    check("t6_first_ready", req_ready, 4'b0001);
    tick();
    check("t6_first_id", out_id, 0);
    clr_req();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
